// File: rtl/lsu_bus_pipelined.sv
// Load/store unit: issues byte-enabled bus accesses, tracks them in an in-order queue, formats load data.
// Latency: issue is combinational; writeback/exception registered, one cycle after response or misaligned accept.
// Backpressure: req_ready_o low while the queue is full, without grant, during flush, or when a bus error pre-empts a misalignment.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of truncating the offset).

package lsu_pkg;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_oper_t;
endpackage

module lsu_bus_pipelined
  import lsu_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  mem_oper_t         mem_oper_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic [31:0]       wb_data_o,
  output logic              exc_valid_o,
  output logic [3:0]        exc_cause_o,
  output logic [31:0]       exc_addr_o,
  output logic              busy_o
);

  localparam int              PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]       FULL_CNT = 3'(MAX_OUTSTANDING);

  // One in-flight access; the full address is kept so a bus error can report mtval.
  typedef struct packed {
    logic              sq;
    logic              is_load;
    mem_oper_t         oper;
    logic [ADDR_W-1:0] addr;
    logic [4:0]        rd;
  } pend_t;

  pend_t            r_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [2:0]       r_cnt;

  logic             r_wb_vld;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_dat;
  logic             r_exc_vld;
  logic [3:0]       r_exc_cause;
  logic [31:0]      r_exc_addr;

  logic        w_is_nop;
  logic        w_is_load;
  logic        w_misalign;
  logic        w_full;
  logic        w_pop;
  logic        w_head_sq;
  logic        w_pop_err;
  logic        w_pop_wb;
  logic        w_mis_acc;
  logic        w_push;
  pend_t       w_head;
  logic [31:0] w_head_addr;
  logic [3:0]  w_be;
  logic [31:0] w_wdat;
  logic [1:0]  w_lane;
  logic [31:0] w_shifted;
  logic [31:0] w_ld_data;

  assign w_is_nop  = (mem_oper_i == MEM_NOP);
  assign w_is_load = mem_oper_i inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfword needs a[0]=0, word needs a[1:0]=0; such accesses trap instead of issuing.
  always_comb begin
    w_misalign = 1'b0;
    case (mem_oper_i)
      MEM_LH, MEM_LHU, MEM_SH: w_misalign = addr_i[0];
      MEM_LW, MEM_SW:          w_misalign = |addr_i[1:0];
      default:                 w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_full      = (r_cnt == FULL_CNT);
  assign w_head      = r_q[r_rd_ptr];
  assign w_head_addr = 32'(w_head.addr);

  // A response with an empty queue is stray and is dropped here.
  assign w_pop     = bus_rvalid_i & (r_cnt != 3'd0);
  // A flush in the response cycle also kills the entry being retired.
  assign w_head_sq = w_head.sq | flush_i;
  assign w_pop_err = w_pop & bus_err_i & ~w_head_sq;
  assign w_pop_wb  = w_pop & ~bus_err_i & ~w_head_sq & w_head.is_load;

  // Bus error on the oldest entry wins; the misaligned request waits a cycle.
  assign w_mis_acc = req_valid_i & ~w_is_nop & w_misalign & ~flush_i & ~w_pop_err;

  // Full blocks the push even if a response frees a slot this same cycle.
  assign bus_req_o   = req_valid_i & ~w_is_nop & ~w_misalign & ~w_full & ~flush_i;
  assign w_push      = bus_req_o & bus_gnt_i;
  assign req_ready_o = req_valid_i & ~flush_i & (w_is_nop | w_push | w_mis_acc);

  assign bus_we_o    = bus_req_o & ~w_is_load;
  assign bus_addr_o  = bus_req_o ? {addr_i[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be_o    = bus_req_o ? w_be : 4'b0000;
  assign bus_wdata_o = bus_req_o ? w_wdat : 32'd0;
  assign busy_o      = (r_cnt != 3'd0);

  // Byte-lane steering for stores; loads always read the whole word.
  always_comb begin
    w_be   = 4'b1111;
    w_wdat = 32'd0;
    case (mem_oper_i)
      MEM_SB: begin
        w_be   = 4'b0001 << addr_i[1:0];
        w_wdat = wdata_i << {addr_i[1:0], 3'b000};
      end
      MEM_SH: begin
        w_be   = 4'b0011 << {addr_i[1], 1'b0};
        w_wdat = wdata_i << {addr_i[1], 4'b0000};
      end
      MEM_SW:  w_wdat = wdata_i;
      default: w_wdat = 32'd0;
    endcase
  end

  // Extract and extend the addressed byte/halfword of the returning word.
  always_comb begin
    w_lane = 2'd0;
    case (w_head.oper)
      MEM_LB, MEM_LBU: w_lane = w_head.addr[1:0];
      MEM_LH, MEM_LHU: w_lane = {w_head.addr[1], 1'b0};
      default:         w_lane = 2'd0;
    endcase
    w_shifted = bus_rdata_i >> {w_lane, 3'b000};
    w_ld_data = w_shifted;
    case (w_head.oper)
      MEM_LB:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      MEM_LBU: w_ld_data = {24'd0, w_shifted[7:0]};
      MEM_LH:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      MEM_LHU: w_ld_data = {16'd0, w_shifted[15:0]};
      default: w_ld_data = w_shifted;
    endcase
  end

  // Pending queue: circular buffer with push on handshake, pop on response, flush marks all squashed.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= 3'd0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_q[i] <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) r_q[i].sq <= 1'b1;
      end
      if (w_push) begin
        r_q[r_wr_ptr].sq      <= 1'b0;
        r_q[r_wr_ptr].is_load <= w_is_load;
        r_q[r_wr_ptr].oper    <= mem_oper_i;
        r_q[r_wr_ptr].addr    <= addr_i[ADDR_W-1:0];
        r_q[r_wr_ptr].rd      <= rd_addr_i;
        r_wr_ptr              <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Registered one-cycle writeback and exception pulses; fields are zero when not valid.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wb_vld    <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_dat    <= 32'd0;
      r_exc_vld   <= 1'b0;
      r_exc_cause <= 4'd0;
      r_exc_addr  <= 32'd0;
    end else begin
      r_wb_vld  <= w_pop_wb;
      r_wb_rd   <= w_pop_wb ? w_head.rd : 5'd0;
      r_wb_dat  <= w_pop_wb ? w_ld_data : 32'd0;
      r_exc_vld <= w_pop_err | w_mis_acc;
      if (w_pop_err) begin
        r_exc_cause <= w_head.is_load ? 4'd5 : 4'd7;
        r_exc_addr  <= w_head_addr;
      end else if (w_mis_acc) begin
        r_exc_cause <= w_is_load ? 4'd4 : 4'd6;
        r_exc_addr  <= addr_i;
      end else begin
        r_exc_cause <= 4'd0;
        r_exc_addr  <= 32'd0;
      end
    end
  end

  assign wb_valid_o   = r_wb_vld;
  assign wb_rd_addr_o = r_wb_rd;
  assign wb_data_o    = r_wb_dat;
  assign exc_valid_o  = r_exc_vld;
  assign exc_cause_o  = r_exc_cause;
  assign exc_addr_o   = r_exc_addr;

endmodule

// File: tb/tb_lsu_bus_pipelined.sv
// Bench for lsu_bus_pipelined: queue-based reference model plus directed scenarios.
// Inputs change 1 time unit after the rising edge; all checks happen on the falling edge.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_lsu_bus_pipelined;
  import lsu_pkg::*;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid;
  mem_oper_t   mem_oper;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        flush;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  logic        req_ready_o, bus_req_o, bus_we_o, wb_valid_o, exc_valid_o, busy_o;
  logic [31:0] bus_addr_o, bus_wdata_o, wb_data_o, exc_addr_o;
  logic [3:0]  bus_be_o, exc_cause_o;
  logic [4:0]  wb_rd_addr_o;

  always #5 clk = ~clk;

  lsu_bus_pipelined #(.MAX_OUTSTANDING(MAXO), .ADDR_W(32)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .mem_oper_i(mem_oper),
    .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd), .flush_i(flush),
    .bus_req_o(bus_req_o), .bus_gnt_i(gnt), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(rvalid), .bus_rdata_i(rdata), .bus_err_i(err),
    .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_addr_o(exc_addr_o),
    .busy_o(busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_load;
    mem_oper_t   op;
    logic [31:0] a;
    logic [4:0]  rd;
    bit          sq;
  } ment_t;

  typedef struct packed {
    logic req;
    logic ready;
    logic mis_acc;
    logic head_err;
  } ev_t;

  ment_t       mq[$];
  logic        m_wb_vld;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_dat;
  logic        m_exc_vld;
  logic [3:0]  m_exc_cause;
  logic [31:0] m_exc_addr;

  function automatic bit f_load(input mem_oper_t op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic bit f_mis(input mem_oper_t op, input logic [31:0] a);
    bit m = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (op inside {MEM_LH, MEM_LHU, MEM_SH}) m = (a % 2) != 0;
    if (op inside {MEM_LW, MEM_SW})          m = (a % 4) != 0;
`else
    m = (op == MEM_NOP) && (a != a);
`endif
    return m;
  endfunction

  function automatic logic [3:0] f_be(input mem_oper_t op, input logic [31:0] a);
    if (op == MEM_SB) return 4'(1 << (a % 4));
    if (op == MEM_SH) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] f_wdat(input mem_oper_t op, input logic [31:0] a, input logic [31:0] w);
    if (op == MEM_SB) return w << (8 * (a % 4));
    if (op == MEM_SH) return ((a % 4) >= 2) ? (w << 16) : w;
    if (op == MEM_SW) return w;
    return 32'd0;
  endfunction

  function automatic logic [31:0] f_fmt(input mem_oper_t op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] b = (d >> (8 * (a % 4))) & 32'hFF;
    logic [31:0] h = (d >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (op)
      MEM_LB:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      MEM_LBU: return b;
      MEM_LH:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      MEM_LHU: return h;
      default: return d;
    endcase
  endfunction

  // What the unit must do with the inputs currently presented.
  function automatic ev_t f_eval();
    ev_t e;
    int  cnt   = mq.size();
    bit  live  = req_valid && (mem_oper != MEM_NOP);
    bit  mis   = live && f_mis(mem_oper, addr);
    e.head_err = rvalid && (cnt > 0) && err && !((cnt > 0) && mq[0].sq) && !flush;
    e.req      = live && !mis && (cnt < MAXO) && !flush;
    e.mis_acc  = mis && !flush && !e.head_err;
    e.ready    = req_valid && !flush && ((mem_oper == MEM_NOP) || (e.req && gnt) || e.mis_acc);
    return e;
  endfunction

  always @(posedge clk or negedge rstn) begin
    ev_t   ev;
    ment_t h;
    ment_t n;
    if (!rstn) begin
      mq.delete();
      m_wb_vld = 0; m_wb_rd = 0; m_wb_dat = 0;
      m_exc_vld = 0; m_exc_cause = 0; m_exc_addr = 0;
    end else begin
      ev = f_eval();
      m_wb_vld = 0; m_wb_rd = 0; m_wb_dat = 0;
      m_exc_vld = 0; m_exc_cause = 0; m_exc_addr = 0;
      if (rvalid && mq.size() > 0) begin
        h = mq.pop_front();
        if (!(h.sq || flush)) begin
          if (err) begin
            m_exc_vld = 1; m_exc_cause = h.is_load ? 4'd5 : 4'd7; m_exc_addr = h.a;
          end else if (h.is_load) begin
            m_wb_vld = 1; m_wb_rd = h.rd; m_wb_dat = f_fmt(h.op, h.a, rdata);
          end
        end
      end
      if (ev.mis_acc) begin
        m_exc_vld = 1; m_exc_cause = f_load(mem_oper) ? 4'd4 : 4'd6; m_exc_addr = addr;
      end
      if (flush) foreach (mq[i]) mq[i].sq = 1;
      if (ev.req && gnt) begin
        n.is_load = f_load(mem_oper); n.op = mem_oper; n.a = addr; n.rd = rd; n.sq = 0;
        mq.push_back(n);
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    ev_t ev;
    ev = f_eval();
    chk("bus_req", {31'd0, bus_req_o}, {31'd0, ev.req});
    chk("req_ready", {31'd0, req_ready_o}, {31'd0, ev.ready});
    chk("busy", {31'd0, busy_o}, {31'd0, mq.size() != 0});
    if (ev.req) begin
      chk("bus_we", {31'd0, bus_we_o}, {31'd0, !f_load(mem_oper)});
      chk("bus_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
      chk("bus_be", {28'd0, bus_be_o}, {28'd0, f_be(mem_oper, addr)});
      chk("bus_wdata", bus_wdata_o, f_wdat(mem_oper, addr, wdata));
    end
    chk("wb_valid", {31'd0, wb_valid_o}, {31'd0, m_wb_vld});
    chk("exc_valid", {31'd0, exc_valid_o}, {31'd0, m_exc_vld});
    if (m_wb_vld) begin
      chk("wb_rd", {27'd0, wb_rd_addr_o}, {27'd0, m_wb_rd});
      chk("wb_data", wb_data_o, m_wb_dat);
    end
    if (m_exc_vld) begin
      chk("exc_cause", {28'd0, exc_cause_o}, {28'd0, m_exc_cause});
      chk("exc_addr", exc_addr_o, m_exc_addr);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 0; mem_oper = MEM_NOP; addr = 0; wdata = 0; rd = 0;
    flush = 0; rvalid = 0; rdata = 0; err = 0;
  endtask

  task automatic issue(input mem_oper_t op, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
    req_valid = 1; mem_oper = op; addr = a; wdata = wd; rd = r;
  endtask

  task automatic respond(input logic [31:0] d, input logic e);
    rvalid = 1; rdata = d; err = e;
  endtask

  // Load with one-cycle response; check literal result in the writeback cycle.
  task automatic load_lit(input string nm, input mem_oper_t op, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp);
    issue(op, a, 32'd0, 5'd5);
    @(negedge clk); chk({nm, "_ready"}, {31'd0, req_ready_o}, 32'd1);
    cyc(); idle(); respond(d, 1'b0);
    cyc(); idle();
    @(negedge clk);
    chk({nm, "_wbv"}, {31'd0, wb_valid_o}, 32'd1);
    chk({nm, "_data"}, wb_data_o, exp);
    chk({nm, "_model"}, m_wb_dat, exp);
  endtask

  initial begin
    idle(); gnt = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_excv", {31'd0, exc_valid_o}, 32'd0);
    chk("rst_wbdata", wb_data_o, 32'd0);
    cyc(); rstn = 1;

    // NOP is accepted without touching the bus
    cyc(); issue(MEM_NOP, 32'h10, 32'd0, 5'd1);
    @(negedge clk);
    chk("nop_ready", {31'd0, req_ready_o}, 32'd1);
    chk("nop_busreq", {31'd0, bus_req_o}, 32'd0);
    cyc(); idle();

    // LB / LBU at 0x1003, LH / LHU at 0x1002
    issue(MEM_LB, 32'h1003, 32'd0, 5'd5);
    @(negedge clk);
    chk("lb_addr", bus_addr_o, 32'h1000);
    chk("lb_be", {28'd0, bus_be_o}, 32'hF);
    cyc(); idle(); respond(32'h80FF_FF7F, 1'b0);
    @(negedge clk); chk("lb_nowb_c1", {31'd0, wb_valid_o}, 32'd0);
    cyc(); idle();
    @(negedge clk);
    chk("lb_wbv", {31'd0, wb_valid_o}, 32'd1);
    chk("lb_data", wb_data_o, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, wb_rd_addr_o}, 32'd5);
    chk("lb_model", m_wb_dat, 32'hFFFF_FF80);
    cyc();
    load_lit("lbu", MEM_LBU, 32'h1003, 32'h80FF_FF7F, 32'h0000_0080);
    cyc();
    load_lit("lh", MEM_LH, 32'h1002, 32'h8001_0000, 32'hFFFF_8001);
    cyc();
    load_lit("lhu", MEM_LHU, 32'h1002, 32'h8001_0000, 32'h0000_8001);
    cyc();

    // SH at 0x2002
    issue(MEM_SH, 32'h2002, 32'h0000_BEEF, 5'd0);
    @(negedge clk);
    chk("sh_be", {28'd0, bus_be_o}, 32'hC);
    chk("sh_wdata", bus_wdata_o, 32'hBEEF_0000);
    chk("sh_addr", bus_addr_o, 32'h2000);
    chk("sh_we", {31'd0, bus_we_o}, 32'd1);
    cyc(); idle(); respond(32'd0, 1'b0);
    cyc(); idle();
    @(negedge clk); chk("sh_nowb", {31'd0, wb_valid_o}, 32'd0);
    cyc();

    // Three back-to-back LW with responses held off
    issue(MEM_LW, 32'h100, 32'd0, 5'd1); cyc();
    issue(MEM_LW, 32'h104, 32'd0, 5'd2); cyc();
    issue(MEM_LW, 32'h108, 32'd0, 5'd3);
    @(negedge clk); chk("bp_stall1", {31'd0, req_ready_o}, 32'd0);
    cyc();
    @(negedge clk); chk("bp_stall2", {31'd0, req_ready_o}, 32'd0);
    cyc(); respond(32'hAAAA_0001, 1'b0);
    @(negedge clk); chk("bp_full_pop", {31'd0, req_ready_o}, 32'd0);
    cyc(); respond(32'hBBBB_0002, 1'b0);
    @(negedge clk);
    chk("bp_accept3", {31'd0, req_ready_o}, 32'd1);
    chk("bp_wb1_rd", {27'd0, wb_rd_addr_o}, 32'd1);
    chk("bp_wb1_dat", wb_data_o, 32'hAAAA_0001);
    cyc(); req_valid = 0; respond(32'hCCCC_0003, 1'b0);
    @(negedge clk);
    chk("bp_wb2_rd", {27'd0, wb_rd_addr_o}, 32'd2);
    cyc(); idle();
    @(negedge clk);
    chk("bp_wb3_rd", {27'd0, wb_rd_addr_o}, 32'd3);
    chk("bp_wb3_dat", wb_data_o, 32'hCCCC_0003);
    chk("bp_idle", {31'd0, busy_o}, 32'd0);
    cyc();

    // LW at 0x3002
    issue(MEM_LW, 32'h3002, 32'd0, 5'd7);
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    chk("mis_noreq", {31'd0, bus_req_o}, 32'd0);
    chk("mis_ready", {31'd0, req_ready_o}, 32'd1);
    cyc(); idle();
    @(negedge clk);
    chk("mis_excv", {31'd0, exc_valid_o}, 32'd1);
    chk("mis_cause", {28'd0, exc_cause_o}, 32'd4);
    chk("mis_addr", exc_addr_o, 32'h3002);
    cyc();
`else
    @(negedge clk);
    chk("mis_req", {31'd0, bus_req_o}, 32'd1);
    chk("mis_addr", bus_addr_o, 32'h3000);
    cyc(); idle(); respond(32'h1234_5678, 1'b0);
    @(negedge clk); chk("mis_noexc", {31'd0, exc_valid_o}, 32'd0);
    cyc(); idle();
    @(negedge clk); chk("mis_lw_data", wb_data_o, 32'h1234_5678);
    cyc();
`endif

    // Flush: blocks a same-cycle request, squashes two pending loads
    issue(MEM_LW, 32'h200, 32'd0, 5'd8); cyc();
    issue(MEM_LW, 32'h204, 32'd0, 5'd9); flush = 1;
    @(negedge clk);
    chk("fl_block_rdy", {31'd0, req_ready_o}, 32'd0);
    chk("fl_block_req", {31'd0, bus_req_o}, 32'd0);
    cyc(); flush = 0;
    cyc(); idle(); flush = 1;
    cyc(); flush = 0; respond(32'h1111_1111, 1'b0);
    @(negedge clk); chk("fl_busy_mid", {31'd0, busy_o}, 32'd1);
    cyc(); respond(32'h2222_2222, 1'b0);
    @(negedge clk);
    chk("fl_nowb1", {31'd0, wb_valid_o}, 32'd0);
    chk("fl_busy_last", {31'd0, busy_o}, 32'd1);
    cyc(); idle();
    @(negedge clk);
    chk("fl_nowb2", {31'd0, wb_valid_o}, 32'd0);
    chk("fl_idle", {31'd0, busy_o}, 32'd0);
    cyc();

    // Store and load access faults
    issue(MEM_SW, 32'h4000, 32'hDEAD_BEEF, 5'd0);
    cyc(); idle(); respond(32'd0, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("st_err_v", {31'd0, exc_valid_o}, 32'd1);
    chk("st_err_cause", {28'd0, exc_cause_o}, 32'd7);
    chk("st_err_addr", exc_addr_o, 32'h4000);
    cyc();
    issue(MEM_LH, 32'h5002, 32'd0, 5'd4);
    cyc(); idle(); respond(32'd0, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("ld_err_cause", {28'd0, exc_cause_o}, 32'd5);
    chk("ld_err_addr", exc_addr_o, 32'h5002);
    chk("ld_err_nowb", {31'd0, wb_valid_o}, 32'd0);
    cyc();

    // Stray response on an empty queue
    respond(32'hFFFF_FFFF, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("stray_nowb", {31'd0, wb_valid_o}, 32'd0);
    chk("stray_noexc", {31'd0, exc_valid_o}, 32'd0);
    cyc();

`ifdef LSU_MISALIGN_TRAP_EN
    // Bus error beats a same-cycle misalignment
    issue(MEM_LW, 32'h600, 32'd0, 5'd2);
    cyc(); issue(MEM_LH, 32'h601, 32'd0, 5'd3); respond(32'd0, 1'b1);
    @(negedge clk); chk("pri_stall", {31'd0, req_ready_o}, 32'd0);
    cyc(); rvalid = 0; err = 0;
    @(negedge clk);
    chk("pri_ready", {31'd0, req_ready_o}, 32'd1);
    chk("pri_cause5", {28'd0, exc_cause_o}, 32'd5);
    cyc(); idle();
    @(negedge clk);
    chk("pri_cause4", {28'd0, exc_cause_o}, 32'd4);
    chk("pri_addr", exc_addr_o, 32'h601);
    cyc();
`endif

    // Asynchronous reset mid-flight discards the queue
    issue(MEM_LW, 32'h700, 32'd0, 5'd11);
    cyc(); idle();
    #2 rstn = 0;
    @(negedge clk); chk("arst_busy", {31'd0, busy_o}, 32'd0);
    cyc(); rstn = 1; respond(32'h5555_5555, 1'b0);
    cyc(); idle();
    @(negedge clk); chk("arst_nowb", {31'd0, wb_valid_o}, 32'd0);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
